// File: rtl/dma_sched_pkg.sv
// Shared definitions for the two-channel DMA request scheduler.
package dma_sched_pkg;

  localparam int unsigned CH_NUM = 2;

  // Encodings are visible through the debug register, so values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Index of the channel selected by a two-bit one-hot grant.
  function automatic logic grant_idx(input logic [CH_NUM-1:0] onehot);
    return onehot[1];
  endfunction

endpackage

// File: rtl/dma_chan_sched_rr_arb2.sv
// Two-input round-robin picker: the channel other than the last-served one
// wins a tie; a single eligible channel always wins.
module rr_arb2
  import dma_sched_pkg::*;
(
  input  logic [CH_NUM-1:0] elig_i,
  input  logic              last_i,
  output logic [CH_NUM-1:0] gnt_o
);

  // Tie goes to the channel not served most recently.
  always_comb begin
    gnt_o = '0;
    if (elig_i[0] && elig_i[1]) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end else begin
      gnt_o = elig_i;
    end
  end

endmodule

// File: rtl/dma_chan_sched.sv
// Two-channel DMA request scheduler: picks an eligible FIFO channel,
// runs the REQ/Active/Done handshake with the SDMA, counts popped words,
// and guards the handshake with a watchdog.
module dma_chan_sched
  import dma_sched_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 10,
  parameter int unsigned TMO_WIDTH = 16
) (
  input  logic                   WBs_CLK_i,
  input  logic                   WBs_RST_i,
  input  logic [1:0]             Ch_Enable_i,
  input  logic [2*CNT_WIDTH-1:0] Ch_Level_i,
  input  logic [1:0]             Ch_Flush_i,
  input  logic [CNT_WIDTH-1:0]   Burst_Len_i,
  input  logic                   Pop_i,
  input  logic                   DMA_Active_i,
  input  logic                   DMA_Done_i,
  input  logic                   Err_Clr_i,
  output logic                   DMA_REQ_o,
  output logic [1:0]             Grant_o,
  output logic [1:0]             Ch_Done_o,
  output logic [CNT_WIDTH-1:0]   Word_Cnt_o,
  output logic                   Tmo_Err_o,
  output logic                   Len_Err_o,
  output logic [1:0]             Fsm_St_o
);

  state_e                state_q, state_d;
  logic [CH_NUM-1:0]     grant_q, grant_d;
  logic [CH_NUM-1:0]     done_q, done_d;
  logic                  req_q, req_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [TMO_WIDTH-1:0]  tmr_q, tmr_d;
  logic                  tmo_err_q, tmo_err_d;
  logic                  len_err_q, len_err_d;
  logic                  last_q, last_d;

  logic [CH_NUM-1:0]     elig;
  logic [CH_NUM-1:0]     arb_gnt;
  logic [TMO_WIDTH-1:0]  tmr_inc;
  logic                  tmo_hit;
  logic                  grant_lost;
  logic                  tmo_set;
  logic                  len_set;

  // Per-channel eligibility from enable, flush, burst length and fill level.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      elig[i] = Ch_Enable_i[i] && !Ch_Flush_i[i] && (Burst_Len_i != '0) &&
                (Ch_Level_i[i*CNT_WIDTH +: CNT_WIDTH] >= Burst_Len_i);
    end
  end

  rr_arb2 u_arb (
    .elig_i (elig),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  // Watchdog fires on the cycle its count would reach all ones.
  always_comb begin
    tmr_inc    = tmr_q + TMO_WIDTH'(1);
    tmo_hit    = (tmr_inc == '1);
    grant_lost = |(grant_q & (~Ch_Enable_i | Ch_Flush_i));
  end

  // Next-state, grant, counter, watchdog and flag-set logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    req_d   = req_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    last_d  = last_q;
    tmo_set = 1'b0;
    len_set = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          grant_d = arb_gnt;
          cnt_d   = '0;
          tmr_d   = '0;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        tmr_d = tmr_inc;
        if (tmo_hit) begin
          tmo_set = 1'b1;
          req_d   = 1'b0;
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (grant_lost) begin
          req_d   = 1'b0;
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (DMA_Active_i) begin
          req_d   = 1'b0;
          state_d = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        tmr_d = tmr_inc;
        if (Pop_i && (cnt_q != '1)) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        if (tmo_hit) begin
          tmo_set = 1'b1;
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (DMA_Done_i) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // DONE spans two cycles: the first raises the done pulse while the
        // grant is still held, the second releases the grant.
        if (done_q == '0) begin
          done_d  = grant_q;
          len_set = (cnt_q != Burst_Len_i);
          last_d  = grant_idx(grant_q);
        end else begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky error flags: a set in the same cycle as a clear wins.
  always_comb begin
    tmo_err_d = tmo_set || (tmo_err_q && !Err_Clr_i);
    len_err_d = len_set || (len_err_q && !Err_Clr_i);
  end

  // State and output registers.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      req_q     <= 1'b0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      tmo_err_q <= 1'b0;
      len_err_q <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      tmo_err_q <= tmo_err_d;
      len_err_q <= len_err_d;
      last_q    <= last_d;
    end
  end

  assign DMA_REQ_o  = req_q;
  assign Grant_o    = grant_q;
  assign Ch_Done_o  = done_q;
  assign Word_Cnt_o = cnt_q;
  assign Tmo_Err_o  = tmo_err_q;
  assign Len_Err_o  = len_err_q;
  assign Fsm_St_o   = state_q;

endmodule

// File: tb/tb_dma_chan_sched.sv
// Bench for dma_chan_sched: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the scheduler.
module tb_dma_chan_sched;

  localparam int CW      = 10;
  localparam int TW      = 10;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int TMO_MAX = (1 << TW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      en = '0;
  logic [2*CW-1:0] level = '0;
  logic [1:0]      flush = '0;
  logic [CW-1:0]   blen = '0;
  logic            pop = 1'b0;
  logic            act = 1'b0;
  logic            done = 1'b0;
  logic            clr = 1'b0;

  logic            DMA_REQ_o;
  logic [1:0]      Grant_o;
  logic [1:0]      Ch_Done_o;
  logic [CW-1:0]   Word_Cnt_o;
  logic            Tmo_Err_o;
  logic            Len_Err_o;
  logic [1:0]      Fsm_St_o;

  int vectors = 0;
  int miscompares = 0;

  dma_chan_sched #(.CNT_WIDTH(CW), .TMO_WIDTH(TW)) dut (
    .WBs_CLK_i    (clk),
    .WBs_RST_i    (rst),
    .Ch_Enable_i  (en),
    .Ch_Level_i   (level),
    .Ch_Flush_i   (flush),
    .Burst_Len_i  (blen),
    .Pop_i        (pop),
    .DMA_Active_i (act),
    .DMA_Done_i   (done),
    .Err_Clr_i    (clr),
    .DMA_REQ_o    (DMA_REQ_o),
    .Grant_o      (Grant_o),
    .Ch_Done_o    (Ch_Done_o),
    .Word_Cnt_o   (Word_Cnt_o),
    .Tmo_Err_o    (Tmo_Err_o),
    .Len_Err_o    (Len_Err_o),
    .Fsm_St_o     (Fsm_St_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, a, e, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 requesting, 2 transferring, 3 completing
  int m_ph = 0, m_own = -1, m_req = 0, m_cnt = 0, m_tmr = 0;
  int m_tmo = 0, m_len = 0, m_last = 1, m_pulse = 0, m_dage = 0;
  int pick;
  bit s_tmo, s_len;

  function automatic bit elig(input int n);
    int lv;
    lv = int'((level >> (n * CW)) & CNT_MAX);
    return en[n] && !flush[n] && (blen != 0) && (lv >= int'(blen));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_own = -1; m_req = 0; m_cnt = 0; m_tmr = 0;
      m_tmo = 0; m_len = 0; m_last = 1; m_pulse = 0; m_dage = 0;
    end else begin
      s_tmo = 0; s_len = 0; m_pulse = 0;
      if (m_ph == 0) begin
        pick = -1;
        if (elig(0) && elig(1)) pick = 1 - m_last;
        else if (elig(0)) pick = 0;
        else if (elig(1)) pick = 1;
        if (pick >= 0) begin
          m_own = pick; m_cnt = 0; m_tmr = 0; m_req = 1; m_ph = 1;
        end
      end else if (m_ph == 1) begin
        m_tmr++;
        if (m_tmr == TMO_MAX) begin
          s_tmo = 1; m_req = 0; m_own = -1; m_ph = 0;
        end else if (!en[m_own] || flush[m_own]) begin
          m_req = 0; m_own = -1; m_ph = 0;
        end else if (act) begin
          m_req = 0; m_ph = 2;
        end
      end else if (m_ph == 2) begin
        if (pop) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        m_tmr++;
        if (m_tmr == TMO_MAX) begin
          s_tmo = 1; m_own = -1; m_ph = 0;
        end else if (done) begin
          m_ph = 3; m_dage = 0;
        end
      end else begin
        if (m_dage == 0) begin
          m_pulse = 1 << m_own;
          s_len = (m_cnt != int'(blen));
          m_last = m_own;
          m_dage = 1;
        end else begin
          m_own = -1; m_ph = 0;
        end
      end
      if (s_tmo) m_tmo = 1; else if (clr) m_tmo = 0;
      if (s_len) m_len = 1; else if (clr) m_len = 0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    check("req",   int'(DMA_REQ_o),  m_req);
    check("grant", int'(Grant_o),    (m_own < 0) ? 0 : (1 << m_own));
    check("done",  int'(Ch_Done_o),  m_pulse);
    check("wcnt",  int'(Word_Cnt_o), m_cnt);
    check("tmo",   int'(Tmo_Err_o),  m_tmo);
    check("lenerr",int'(Len_Err_o),  m_len);
    check("fsm",   int'(Fsm_St_o),   m_ph);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string nm);
    int w;
    w = 0;
    while (!DMA_REQ_o && w < 64) begin
      step();
      w++;
    end
    check({nm, "_req_seen"}, int'(DMA_REQ_o), 1);
  endtask

  // One transfer: Active, npop pops with Done on the last one.
  task automatic do_burst(input int npop, input bit drop_en, output int g);
    wait_req("burst");
    g = int'(Grant_o);
    act = 1'b1; step(); act = 1'b0;
    if (npop == 0) begin
      done = 1'b1; if (drop_en) en = '0;
      step(); done = 1'b0;
    end
    for (int i = 0; i < npop; i++) begin
      pop = 1'b1;
      if (i == npop - 1) begin
        done = 1'b1;
        if (drop_en) en = '0;
      end
      step();
      pop = 1'b0; done = 1'b0;
    end
  endtask

  initial begin
    int g, n;
    int exp_seq[4];
    exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 1; exp_seq[3] = 2;

    // Reset values
    step(); step();
    check("rst_req",  int'(DMA_REQ_o), 0);
    check("rst_grant",int'(Grant_o), 0);
    check("rst_fsm",  int'(Fsm_St_o), 0);
    rst = 1'b0;
    step();

    // Round robin with both channels continuously eligible
    en = 2'b11; blen = 10'd4;
    level[0 +: CW] = 10'd4; level[CW +: CW] = 10'd4;
    for (int b = 0; b < 4; b++) begin
      do_burst(4, (b == 3), g);
      check("rr_grant", g, exp_seq[b]);
    end
    step(); step(); step();

    // Single channel, 256-word burst
    en = 2'b01; blen = 10'd256; level[0 +: CW] = 10'd256;
    step();
    check("t1_req", int'(DMA_REQ_o), 1);
    check("t1_grant", int'(Grant_o), 1);
    do_burst(256, 1'b1, g);
    check("t1_fsm_done", int'(Fsm_St_o), 3);
    step();
    check("t1_chdone", int'(Ch_Done_o), 1);
    check("t1_wcnt", int'(Word_Cnt_o), 256);
    check("t1_lenerr", int'(Len_Err_o), 0);
    step();
    check("t1_idle", int'(Fsm_St_o), 0);
    check("t1_chdone_off", int'(Ch_Done_o), 0);

    // Ch1 flushed during REQ; ch1 keeps priority afterwards
    blen = 10'd4; level[0 +: CW] = 10'd4; level[CW +: CW] = 10'd4;
    en = 2'b10;
    wait_req("fl");
    check("fl_grant", int'(Grant_o), 2);
    flush = 2'b10;
    step();
    check("fl_req_drop", int'(DMA_REQ_o), 0);
    check("fl_grant_clr", int'(Grant_o), 0);
    check("fl_nodone", int'(Ch_Done_o), 0);
    check("fl_idle", int'(Fsm_St_o), 0);
    flush = 2'b00; en = 2'b11;
    do_burst(4, 1'b1, g);
    check("fl_prio", g, 2);
    step(); step(); step();

    // Watchdog: Active never returned
    en = 2'b01;
    wait_req("wd");
    n = 0;
    while (DMA_REQ_o && n < TMO_MAX + 100) begin
      n++;
      step();
    end
    en = 2'b00;
    check("wd_cycles", n, TMO_MAX);
    check("wd_tmo", int'(Tmo_Err_o), 1);
    check("wd_idle", int'(Fsm_St_o), 0);
    step();
    clr = 1'b1; step(); clr = 1'b0;
    check("wd_clr", int'(Tmo_Err_o), 0);

    // Short burst: Done after 200 of 256 words
    en = 2'b01; blen = 10'd256; level[0 +: CW] = 10'd300;
    do_burst(200, 1'b1, g);
    step();
    check("le_chdone", int'(Ch_Done_o), 1);
    check("le_lenerr", int'(Len_Err_o), 1);
    check("le_wcnt", int'(Word_Cnt_o), 200);
    step(); step();
    clr = 1'b1; step(); clr = 1'b0;

    // Asynchronous reset in the middle of a transfer
    en = 2'b01; blen = 10'd4; level[0 +: CW] = 10'd4;
    wait_req("ar");
    act = 1'b1; step(); act = 1'b0;
    pop = 1'b1; step(); step(); pop = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("ar_req", int'(DMA_REQ_o), 0);
    check("ar_grant", int'(Grant_o), 0);
    check("ar_wcnt", int'(Word_Cnt_o), 0);
    check("ar_fsm", int'(Fsm_St_o), 0);
    en = 2'b00;
    step();
    rst = 1'b0;
    done = 1'b1; step(); done = 1'b0;
    check("ar_ign_done", int'(Ch_Done_o), 0);
    step();
    check("ar_ign_done2", int'(Ch_Done_o), 0);
    check("ar_still_idle", int'(Fsm_St_o), 0);

    // Randomized traffic
    blen = 10'd3;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) en = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) blen = 10'($urandom_range(0, 8));
      level[0 +: CW]  = 10'($urandom_range(0, 12));
      level[CW +: CW] = 10'($urandom_range(0, 12));
      flush[0] = ($urandom_range(0, 15) == 0);
      flush[1] = ($urandom_range(0, 15) == 0);
      pop  = ($urandom_range(0, 1) == 1);
      act  = ($urandom_range(0, 2) == 0);
      done = ($urandom_range(0, 5) == 0);
      clr  = ($urandom_range(0, 19) == 0);
      step();
    end
    en = '0; flush = '0; pop = 1'b0; act = 1'b0; done = 1'b0; clr = 1'b0;
    step(); step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1);
  end

endmodule
